// File: rtl/serial2_adder_pkg.sv
// Shared types and constants for the 2-bit-per-cycle serial adder.
package serial2_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32'd8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Step counter width; a 2-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w / 32'd2 > 32'd1) ? $clog2(w / 32'd2) : 32'd1;
  endfunction

endpackage

// File: rtl/serial2_adder_add2_slice.sv
// Combinational 2-bit ripple adder slice used once per serial step.
module add2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic c1_s;

  // Two chained full adders.
  always_comb begin
    s[0]  = a[0] ^ b[0] ^ cin;
    c1_s  = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
    s[1]  = a[1] ^ b[1] ^ c1_s;
    cout  = (a[1] & b[1]) | (a[1] & c1_s) | (b[1] & c1_s);
  end

endmodule

// File: rtl/serial2_adder.sv
// Serial adder processing two bits per clock with valid/ready handshakes.
// Optional carry-in port enabled by defining SERIAL2_ADDER_CIN_EN.
module serial2_adder
  import serial2_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL2_ADDER_CIN_EN
  input  logic             in_cin,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH / 32'd2 - 32'd1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [1:0]       slice_s;
  logic             slice_cout_s;
  logic             cin_seed_s;
  logic [WIDTH+1:0] sum_shift_s;

`ifdef SERIAL2_ADDER_CIN_EN
  assign cin_seed_s = in_cin;
`else
  assign cin_seed_s = 1'b0;
`endif

  add2_slice u_slice (
    .a    (a_q[1:0]),
    .b    (b_q[1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout_s)
  );

  // New sum bits enter at the top so the LSB pair lands at bit 0 after the last step.
  assign sum_shift_s = {slice_s, sum_q} >> 2;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = cin_seed_s;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 2;
        b_d     = b_q >> 2;
        sum_d   = sum_shift_s[WIDTH-1:0];
        carry_d = slice_cout_s;
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;

endmodule

// File: doc/serial2_adder.md
SERIAL2_ADDER -- requirements
Module: serial2_adder

Interface
REQ-001 Parameter WIDTH SHALL be: default 8; operand width in bits; even; at least 2.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 Port rst SHALL be: input, 1 bit, reset, asynchronous, active-high.
REQ-004 Port in_valid SHALL be: input, 1 bit, operand pair offered.
REQ-005 Port in_ready SHALL be: output, 1 bit, block can accept an operand pair.
REQ-006 Port in_a SHALL be: input, WIDTH bits, operand A.
REQ-007 Port in_b SHALL be: input, WIDTH bits, operand B.
REQ-008 Port out_valid SHALL be: output, 1 bit, result held on out_sum/out_cout.
REQ-009 Port out_ready SHALL be: input, 1 bit, consumer takes the result.
REQ-010 Port out_sum SHALL be: output, WIDTH bits, sum modulo 2^WIDTH.
REQ-011 Port out_cout SHALL be: output, 1 bit, carry out of bit WIDTH-1.

Function
REQ-012 The block SHALL be an FSM with three states: IDLE, RUN and DONE.
REQ-013 IDLE SHALL drive in_ready=1; in_valid=1 on an edge SHALL load in_a/in_b into shift registers, load the carry register with the carry-in per REQ-022, clear the step counter and move to RUN.
REQ-014 RUN SHALL add, on each edge, the two LSBs of the A/B shift registers plus the carry register through one 2-bit slice.
REQ-015 The 2 sum bits SHALL enter the top of the sum shift register, the A/B registers SHALL shift right by 2, and the carry register SHALL take the slice carry-out.
REQ-016 The step counter SHALL count 0..WIDTH/2-1; on the edge processing step WIDTH/2-1 the FSM SHALL move to DONE.
REQ-017 out_valid SHALL be 1 only in DONE, first visible WIDTH/2 edges after the accepting edge (4 for WIDTH=8).
REQ-018 In DONE, out_sum/out_cout SHALL hold stable until out_valid and out_ready are both 1 on an edge; then the FSM SHALL return to IDLE.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored; no same-cycle accept on result release; throughput is one operation per WIDTH/2+2 cycles.
REQ-020 out_ready SHALL be ignored outside DONE; a stalled DONE state SHALL hold indefinitely with no change to outputs.

Reset
REQ-021 When rst is high, the block SHALL asynchronously force state IDLE, counter 0, carry 0, all shift registers 0, in_ready=1, out_valid=0, out_sum=0 and out_cout=0; an operation in progress SHALL be discarded, with no result ever presented.

Configuration
REQ-022 When macro SERIAL2_ADDER_CIN_EN is defined, an input port in_cin (1 bit) SHALL exist; it SHALL be sampled with the operands on the accepting edge and SHALL seed the carry register.
REQ-023 When SERIAL2_ADDER_CIN_EN is undefined, in_cin SHALL be absent and the carry register SHALL be seeded with 0.

Structure
REQ-024 A package serial2_adder_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default width constant.
REQ-025 The 2-bit add SHALL be a combinational sub-module add2_slice with inputs a[1:0], b[1:0], cin and outputs s[1:0], cout; it SHALL be instantiated exactly once.
REQ-026 Counter width SHALL be $clog2(WIDTH/2), with a minimum of 1.

Verification (WIDTH=8)
REQ-027 Bench SHALL cover basic add: in_a=0x5A, in_b=0x3C, out_ready=1 -> out_valid 4 edges after accept, out_sum=0x96, out_cout=0, then IDLE.
REQ-028 Bench SHALL cover overflow: in_a=0xFF, in_b=0x01 -> out_sum=0x00, out_cout=1.
REQ-029 Bench SHALL cover backpressure: out_ready=0 for 10 cycles after out_valid -> out_sum/out_cout stable and in_ready=0 throughout; result released on the first out_ready=1 edge.
REQ-030 Bench SHALL cover reset mid-op: rst pulsed 2 edges after accepting 0xAA+0x55 -> out_valid=0 and in_ready=1 immediately; the next op 0x01+0x02 yields 0x03.
REQ-031 Bench SHALL cover ignored input: in_valid held 1 with changing operands during RUN -> result reflects only the accepted pair.
REQ-032 With SERIAL2_ADDER_CIN_EN: 0xFF+0x00 with in_cin=1 -> out_sum=0x00, out_cout=1; 0x10+0x01 with in_cin=1 -> 0x12, out_cout=0.
